// File: rtl/fifo2sl_ctrl.sv
// Transceiver-side controller between the bridge's command/response async FIFOs
// and the serial-line core: decodes commands, launches TX, reports RX and status.
module fifo2sl_ctrl #(
  parameter logic [1:0] CONFIG_MODIFIER  = 2'd0,
  parameter logic [1:0] DATA_MODIFIER    = 2'd1,
  parameter logic [1:0] STATUS_MODIFIER  = 2'd2,
  parameter logic [1:0] CHANNEL_MODIFIER = 2'd3,
  parameter int         CONFIG_WIDTH     = 16,
  parameter int         CHANNEL_WIDTH    = 2,
  parameter int         WRF              = 3
) (
  input  logic                     pclk,
  input  logic                     preset_n,
  input  logic                     cmd_empty,
  input  logic [33:0]              cmd_data,
  output logic                     cmd_inc,
  input  logic                     rsp_full,
  output logic [33:0]              rsp_data,
  output logic                     rsp_inc,
  output logic [CONFIG_WIDTH-1:0]  config_o,
  output logic [CHANNEL_WIDTH-1:0] channel_o,
  output logic [31:0]              tx_data,
  output logic                     tx_start,
  input  logic                     tx_busy,
  input  logic                     rx_valid,
  input  logic [31:0]              rx_data,
  input  logic                     rx_error
);

  localparam int TXD = 1;
  localparam int RXE = 2;
  localparam int DRP = 4;
  localparam int OVR = 5;

  typedef enum logic [5:0] {
    S_IDLE = 6'b000001,
    S_EXEC = 6'b000010,
    S_TXW  = 6'b000100,
    S_ECHO = 6'b001000,
    S_PRX  = 6'b010000,
    S_PST  = 6'b100000
  } state_t;

  state_t                   state_q, state_d;
  logic [CONFIG_WIDTH-1:0]  config_q, config_d;
  logic [CHANNEL_WIDTH-1:0] channel_q, channel_d;
  logic [31:0]              tx_data_q, tx_data_d;
  logic [31:0]              rx_hold_q, rx_hold_d;
  logic                     rx_pend_q, rx_pend_d;
  logic                     st_pend_q, st_pend_d;
  logic [5:1]               sticky_q, sticky_d;
  logic [1:0]               echo_mod_q, echo_mod_d;
  logic                     tx_busy_q;

  logic [1:0]  cmd_mod;
  logic [31:0] echo_val;
  logic [7:0]  status_w;
  logic        drop, rx_taken;

  assign cmd_mod  = cmd_data[33:32];
  assign echo_val = (echo_mod_q == CONFIG_MODIFIER) ?
                    {{(32-CONFIG_WIDTH){1'b0}}, config_q} :
                    {{(32-CHANNEL_WIDTH){1'b0}}, channel_q};
  assign status_w = {2'b00, sticky_q, tx_busy};

  always_comb begin
    state_d    = state_q;
    config_d   = config_q;
    channel_d  = channel_q;
    tx_data_d  = tx_data_q;
    rx_hold_d  = rx_hold_q;
    rx_pend_d  = rx_pend_q;
    st_pend_d  = st_pend_q;
    sticky_d   = sticky_q;
    echo_mod_d = echo_mod_q;
    cmd_inc    = 1'b0;
    rsp_inc    = 1'b0;
    rsp_data   = '0;
    tx_start   = 1'b0;
    drop       = 1'b0;
    rx_taken   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_pend_q)       state_d = S_PRX;
        else if (st_pend_q)  state_d = S_PST;
        else if (!cmd_empty) state_d = S_EXEC;
      end
      S_EXEC: begin
        cmd_inc    = 1'b1;
        echo_mod_d = cmd_mod;
        if (cmd_mod == CONFIG_MODIFIER) begin
          config_d = cmd_data[CONFIG_WIDTH-1:0];
          state_d  = S_ECHO;
        end else if (cmd_mod == CHANNEL_MODIFIER) begin
          channel_d = cmd_data[CHANNEL_WIDTH-1:0];
          state_d   = S_ECHO;
        end else if (cmd_mod == DATA_MODIFIER && channel_q == '0) begin
          tx_data_d = cmd_data[31:0];
          state_d   = S_TXW;
        end else begin
          drop    = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_TXW: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_ECHO: begin
        if (!rsp_full) begin
          rsp_inc  = 1'b1;
          rsp_data = {echo_mod_q, echo_val};
          state_d  = S_IDLE;
        end
      end
      S_PRX: begin
        if (!rsp_full) begin
          rsp_inc  = 1'b1;
          rsp_data = {DATA_MODIFIER, rx_hold_q};
          rx_taken = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_PST: begin
        if (!rsp_full) begin
          rsp_inc   = 1'b1;
          rsp_data  = {STATUS_MODIFIER, 24'd0, status_w};
          sticky_d  = '0;
          st_pend_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Set events are applied after the status-push clear so a same-cycle set survives.
    if (rx_taken) begin
      rx_pend_d     = 1'b0;
      sticky_d[WRF] = 1'b1;
      st_pend_d     = 1'b1;
    end
    if (drop) begin
      sticky_d[DRP] = 1'b1;
      st_pend_d     = 1'b1;
    end
    if (tx_busy_q && !tx_busy) begin
      sticky_d[TXD] = 1'b1;
      st_pend_d     = 1'b1;
    end
    if (rx_valid) begin
      rx_hold_d = rx_data;
      rx_pend_d = 1'b1;
      if (rx_error) sticky_d[RXE] = 1'b1;
      // A word being pushed this cycle is not lost, so it is not an overrun.
      if (rx_pend_q && !rx_taken) begin
        sticky_d[OVR] = 1'b1;
        st_pend_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q    <= S_IDLE;
      config_q   <= '0;
      channel_q  <= '0;
      tx_data_q  <= '0;
      rx_hold_q  <= '0;
      rx_pend_q  <= 1'b0;
      st_pend_q  <= 1'b0;
      sticky_q   <= '0;
      echo_mod_q <= '0;
      tx_busy_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      config_q   <= config_d;
      channel_q  <= channel_d;
      tx_data_q  <= tx_data_d;
      rx_hold_q  <= rx_hold_d;
      rx_pend_q  <= rx_pend_d;
      st_pend_q  <= st_pend_d;
      sticky_q   <= sticky_d;
      echo_mod_q <= echo_mod_d;
      tx_busy_q  <= tx_busy;
    end
  end

  assign config_o  = config_q;
  assign channel_o = channel_q;
  assign tx_data   = tx_data_q;

endmodule

// File: tb/tb_fifo2sl_ctrl.sv
// Directed bench for fifo2sl_ctrl: inputs driven at the falling edge, outputs
// checked 1ns later against hand-computed values.
module tb_fifo2sl_ctrl;
  logic        pclk, preset_n;
  logic        cmd_empty, cmd_inc;
  logic [33:0] cmd_data;
  logic        rsp_full, rsp_inc;
  logic [33:0] rsp_data;
  logic [15:0] config_o;
  logic [1:0]  channel_o;
  logic [31:0] tx_data;
  logic        tx_start, tx_busy;
  logic        rx_valid, rx_error;
  logic [31:0] rx_data;

  int checks = 0;
  int errors = 0;

  fifo2sl_ctrl dut (
    .pclk(pclk), .preset_n(preset_n),
    .cmd_empty(cmd_empty), .cmd_data(cmd_data), .cmd_inc(cmd_inc),
    .rsp_full(rsp_full), .rsp_data(rsp_data), .rsp_inc(rsp_inc),
    .config_o(config_o), .channel_o(channel_o),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_error(rx_error)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge pclk);
  endtask

  task automatic settle();
    #1;
  endtask

  logic [86:0] all_outs;
  assign all_outs = {cmd_inc, rsp_inc, tx_start, rsp_data, config_o, channel_o, tx_data};

  initial begin
    preset_n = 1'b0; cmd_empty = 1'b1; cmd_data = '0; rsp_full = 1'b0;
    tx_busy = 1'b0; rx_valid = 1'b0; rx_data = '0; rx_error = 1'b0;

    // Reset and quiet idle
    repeat (3) cyc();
    settle(); chk("reset_outs", 128'(all_outs), 128'(0));
    cyc(); preset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(); settle(); chk("idle_quiet", 128'(all_outs), 128'(0));
    end

    // Config write and echo
    cyc(); cmd_data = {2'd0, 32'h0000_A5C3}; cmd_empty = 1'b0;
    settle(); chk("cfg_no_pop_idle", 128'(cmd_inc), 128'(0));
    cyc(); settle(); chk("cfg_pop", 128'(cmd_inc), 128'(1));
    cyc(); cmd_empty = 1'b1;
    settle(); chk("cfg_value", 128'(config_o), 128'(16'hA5C3));
    chk("cfg_echo_inc", 128'(rsp_inc), 128'(1));
    chk("cfg_echo_data", 128'(rsp_data), 128'(34'h0_0000_A5C3));
    cyc(); settle(); chk("cfg_after", 128'({rsp_inc, cmd_inc, rsp_data}), 128'(0));

    // Transmit with busy transmitter
    cyc(); cmd_data = {2'd1, 32'hDEAD_BEEF}; cmd_empty = 1'b0; tx_busy = 1'b1;
    cyc(); settle(); chk("tx_pop", 128'(cmd_inc), 128'(1));
    cyc(); cmd_empty = 1'b1;
    settle(); chk("tx_data", 128'(tx_data), 128'(32'hDEAD_BEEF));
    chk("tx_wait0", 128'(tx_start), 128'(0));
    cyc(); settle(); chk("tx_wait1", 128'(tx_start), 128'(0));
    cyc(); settle(); chk("tx_wait2", 128'(tx_start), 128'(0));
    cyc(); tx_busy = 1'b0;
    settle(); chk("tx_start", 128'(tx_start), 128'(1));
    cyc(); tx_busy = 1'b1;
    settle(); chk("tx_start_once", 128'({tx_start, rsp_inc}), 128'(0));
    cyc(); settle(); chk("st1_inc", 128'(rsp_inc), 128'(1));
    chk("st1_data", 128'(rsp_data), 128'(34'h2_0000_0003));
    cyc(); settle(); chk("st1_single", 128'(rsp_inc), 128'(0));
    cyc(); settle(); chk("busy_quiet", 128'({rsp_inc, tx_start}), 128'(0));
    cyc(); tx_busy = 1'b0;
    cyc(); settle(); chk("st2_wait", 128'(rsp_inc), 128'(0));
    cyc(); settle(); chk("st2_data", 128'({rsp_inc, rsp_data}), 128'({1'b1, 34'h2_0000_0002}));

    // Switch to receiver mode
    cyc(); cmd_data = {2'd3, 32'h0000_0001}; cmd_empty = 1'b0;
    cyc(); settle(); chk("ch_pop", 128'(cmd_inc), 128'(1));
    cyc(); cmd_empty = 1'b1;
    settle(); chk("ch_value", 128'(channel_o), 128'(2'd1));
    chk("ch_echo", 128'({rsp_inc, rsp_data}), 128'({1'b1, 34'h3_0000_0001}));

    // Single received word
    cyc(); rx_valid = 1'b1; rx_data = 32'h1234_5678;
    cyc(); rx_valid = 1'b0;
    settle(); chk("rx_wait", 128'(rsp_inc), 128'(0));
    cyc(); settle(); chk("rx_push", 128'({rsp_inc, rsp_data}), 128'({1'b1, 34'h1_1234_5678}));
    cyc(); settle(); chk("rx_gap", 128'(rsp_inc), 128'(0));
    cyc(); settle(); chk("rx_status", 128'({rsp_inc, rsp_data}), 128'({1'b1, 34'h2_0000_0008}));

    // Overrun with error on the second word
    cyc(); rx_valid = 1'b1; rx_data = 32'hAAAA_0001;
    cyc(); rx_data = 32'hBBBB_0002; rx_error = 1'b1;
    cyc(); rx_valid = 1'b0; rx_error = 1'b0;
    settle(); chk("ovr_push", 128'({rsp_inc, rsp_data}), 128'({1'b1, 34'h1_BBBB_0002}));
    cyc(); settle(); chk("ovr_gap", 128'(rsp_inc), 128'(0));
    cyc(); settle(); chk("ovr_status", 128'({rsp_inc, rsp_data}), 128'({1'b1, 34'h2_0000_002C}));

    // Data word in receiver mode is dropped
    cyc(); cmd_data = {2'd1, 32'h0000_0055}; cmd_empty = 1'b0;
    cyc(); settle(); chk("drop_pop", 128'(cmd_inc), 128'(1));
    cyc(); cmd_empty = 1'b1;
    settle(); chk("drop_no_tx", 128'({tx_start, rsp_inc, tx_data}), 128'({2'b00, 32'hDEAD_BEEF}));
    cyc(); settle(); chk("drop_status", 128'({rsp_inc, rsp_data}), 128'({1'b1, 34'h2_0000_0010}));

    // Response FIFO full during echo
    cyc(); cmd_data = {2'd0, 32'h0000_1234}; cmd_empty = 1'b0;
    cyc(); settle(); chk("full_pop", 128'(cmd_inc), 128'(1));
    cyc(); cmd_data = {2'd3, 32'h0000_0000}; rsp_full = 1'b1;
    settle(); chk("full_hold0", 128'({rsp_inc, cmd_inc, rsp_data}), 128'(0));
    for (int i = 0; i < 9; i++) begin
      cyc(); settle(); chk("full_hold", 128'({rsp_inc, cmd_inc, rsp_data}), 128'(0));
    end
    cyc(); rsp_full = 1'b0;
    settle(); chk("full_release", 128'({rsp_inc, rsp_data}), 128'({1'b1, 34'h0_0000_1234}));
    cyc(); settle(); chk("full_single", 128'({rsp_inc, cmd_inc}), 128'(0));
    cyc(); settle(); chk("next_pop", 128'(cmd_inc), 128'(1));
    cyc(); cmd_empty = 1'b1;
    settle(); chk("ch0_echo", 128'({rsp_inc, rsp_data, channel_o}), 128'({1'b1, 34'h3_0000_0000, 2'd0}));

    // Reset while waiting on the transmitter
    cyc(); cmd_data = {2'd1, 32'hCAFE_F00D}; cmd_empty = 1'b0; tx_busy = 1'b1;
    cyc(); settle(); chk("rst_tx_pop", 128'(cmd_inc), 128'(1));
    cyc(); cmd_empty = 1'b1;
    settle(); chk("rst_in_txwait", 128'({tx_start, tx_data, config_o}), 128'({1'b0, 32'hCAFE_F00D, 16'h1234}));
    cyc(); preset_n = 1'b0;
    settle(); chk("rst_async", 128'(all_outs), 128'(0));
    cyc(); tx_busy = 1'b0;
    settle(); chk("rst_no_start", 128'(all_outs), 128'(0));
    cyc(); preset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(); settle(); chk("post_rst_quiet", 128'(all_outs), 128'(0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
